// File: rtl/sample_scheduler.sv
// Heart-rate chain front end: oversampled SPI word capture and a TLC5620-style DAC serialiser.
// Both paths run on clk; they share nothing but the reset.
module sample_scheduler #(
  parameter int unsigned FRAME_BITS  = 16,
  parameter int unsigned DAC_DIV     = 4,
  parameter int unsigned IDLE_CYCLES = 256,
  parameter logic [1:0]  DAC_ADDR    = 2'b00,
  parameter logic        DAC_RNG     = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sck,
  input  logic       sdo,
  output logic [9:0] sample,
  output logic       sample_valid,
  input  logic [9:0] filt_sample,
  input  logic       filt_valid,
  output logic       DACserial,
  output logic       DACclk,
  output logic       load,
  output logic       LDAC,
  output logic       busy,
  output logic [7:0] overrun_count
);

  localparam int unsigned BIT_W  = $clog2(FRAME_BITS + 1);
  localparam int unsigned IDLE_W = $clog2(IDLE_CYCLES + 1);
  localparam int unsigned CNT_W  = (DAC_DIV > 1) ? $clog2(DAC_DIV) : 1;

  localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(FRAME_BITS - 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_CYCLES);
  localparam logic [CNT_W-1:0]  DIV_LAST = CNT_W'(DAC_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_HI, S_LO, S_LOAD} dac_state_e;

  // ---------------------------------------------------------------------------
  // SPI capture
  // ---------------------------------------------------------------------------
  logic                  sck_meta_q, sck_sync_q, sck_prev_q;
  logic                  sdo_meta_q, sdo_sync_q;
  logic [FRAME_BITS-1:0] word_q, word_d;
  logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [IDLE_W-1:0]     idle_cnt_q, idle_cnt_d;
  logic                  frame_done_q, frame_done_d;
  logic [9:0]            sample_q, sample_d;
  logic                  sample_valid_q, sample_valid_d;
  logic                  sck_rise, sck_edge;

  assign sck_rise = sck_sync_q & ~sck_prev_q;
  assign sck_edge = sck_sync_q ^ sck_prev_q;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    word_d         = word_q;
    bit_cnt_d      = bit_cnt_q;
    idle_cnt_d     = idle_cnt_q;
    frame_done_d   = 1'b0;
    sample_d       = sample_q;
    sample_valid_d = 1'b0;

    if (frame_done_q) begin
      sample_d       = word_q[9:0];
      sample_valid_d = 1'b1;
    end

    if (sck_edge) begin
      idle_cnt_d = '0;
    end else if (idle_cnt_q != IDLE_MAX) begin
      idle_cnt_d = idle_cnt_q + IDLE_W'(1);
    end

    // A stalled partial word is dropped; a rise in the same cycle starts a fresh word.
    if (idle_cnt_q == IDLE_MAX) bit_cnt_d = '0;

    if (sck_rise) begin
      word_d = {word_q[FRAME_BITS-2:0], sdo_sync_q};
      if (bit_cnt_d == LAST_BIT) begin
        bit_cnt_d    = '0;
        frame_done_d = 1'b1;
      end else begin
        bit_cnt_d = bit_cnt_d + BIT_W'(1);
      end
    end
  end

  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sck_meta_q     <= 1'b0;
      sck_sync_q     <= 1'b0;
      sck_prev_q     <= 1'b0;
      sdo_meta_q     <= 1'b0;
      sdo_sync_q     <= 1'b0;
      word_q         <= '0;
      bit_cnt_q      <= '0;
      idle_cnt_q     <= '0;
      frame_done_q   <= 1'b0;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
    end else begin
      sck_meta_q     <= sck;
      sck_sync_q     <= sck_meta_q;
      sck_prev_q     <= sck_sync_q;
      sdo_meta_q     <= sdo;
      sdo_sync_q     <= sdo_meta_q;
      word_q         <= word_d;
      bit_cnt_q      <= bit_cnt_d;
      idle_cnt_q     <= idle_cnt_d;
      frame_done_q   <= frame_done_d;
      sample_q       <= sample_d;
      sample_valid_q <= sample_valid_d;
    end
  end

  // ---------------------------------------------------------------------------
  // DAC serialiser
  // ---------------------------------------------------------------------------
  dac_state_e       state_q;
  logic [CNT_W-1:0] div_cnt_q;
  logic [3:0]       idx_q, idx_nxt;
  logic [10:0]      word11_q, dac_word;
  logic             dacserial_q, dacclk_q, load_q, busy_q;
  logic [7:0]       overrun_q, overrun_d;
  logic             div_last;

  assign dac_word = {DAC_ADDR, DAC_RNG, filt_sample[9:2]};
  assign div_last = (div_cnt_q == DIV_LAST);
  assign idx_nxt  = idx_q - 4'd1;

  always_comb begin
    overrun_d = overrun_q;
    if (filt_valid && state_q != S_IDLE && overrun_q != 8'hFF) overrun_d = overrun_q + 8'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      div_cnt_q   <= '0;
      idx_q       <= '0;
      word11_q    <= '0;
      dacserial_q <= 1'b0;
      dacclk_q    <= 1'b0;
      load_q      <= 1'b1;
      busy_q      <= 1'b0;
      overrun_q   <= '0;
    end else begin
      overrun_q <= overrun_d;
      unique case (state_q)
        S_IDLE: begin
          if (filt_valid) begin
            word11_q    <= dac_word;
            idx_q       <= 4'd10;
            div_cnt_q   <= '0;
            dacserial_q <= dac_word[10];
            dacclk_q    <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= S_HI;
          end
        end
        S_HI: begin
          if (div_last) begin
            div_cnt_q <= '0;
            dacclk_q  <= 1'b0;
            state_q   <= S_LO;
          end else begin
            div_cnt_q <= div_cnt_q + CNT_W'(1);
          end
        end
        S_LO: begin
          if (div_last) begin
            div_cnt_q <= '0;
            if (idx_q != 4'd0) begin
              idx_q       <= idx_nxt;
              dacserial_q <= word11_q[idx_nxt];
              dacclk_q    <= 1'b1;
              state_q     <= S_HI;
            end else begin
              load_q  <= 1'b0;
              state_q <= S_LOAD;
            end
          end else begin
            div_cnt_q <= div_cnt_q + CNT_W'(1);
          end
        end
        S_LOAD: begin
          if (div_last) begin
            div_cnt_q <= '0;
            load_q    <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= S_IDLE;
          end else begin
            div_cnt_q <= div_cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // The DAC takes only the top 8 sample bits; the SPI MSB falls off the shift register.
  logic unused_bits;
  assign unused_bits = ^{filt_sample[1:0], word_q[FRAME_BITS-1]};

  assign sample        = sample_q;
  assign sample_valid  = sample_valid_q;
  assign DACserial     = dacserial_q;
  assign DACclk        = dacclk_q;
  assign load          = load_q;
  assign LDAC          = 1'b0;
  assign busy          = busy_q;
  assign overrun_count = overrun_q;

endmodule

// File: tb/tb_sample_scheduler.sv
// Directed bench for sample_scheduler: SPI capture, idle discard, DAC serialisation,
// overrun accounting and asynchronous reset mid-transfer.
module tb_sample_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       sck;
  logic       sdo;
  logic [9:0] sample;
  logic       sample_valid;
  logic [9:0] filt_sample;
  logic       filt_valid;
  logic       DACserial;
  logic       DACclk;
  logic       load;
  logic       LDAC;
  logic       busy;
  logic [7:0] overrun_count;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int strobes  = 0;
  int last_strobe_cyc = 0;
  int last_rise_cyc   = 0;

  sample_scheduler dut (
    .clk           (clk),
    .reset         (reset),
    .sck           (sck),
    .sdo           (sdo),
    .sample        (sample),
    .sample_valid  (sample_valid),
    .filt_sample   (filt_sample),
    .filt_valid    (filt_valid),
    .DACserial     (DACserial),
    .DACclk        (DACclk),
    .load          (load),
    .LDAC          (LDAC),
    .busy          (busy),
    .overrun_count (overrun_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (sample_valid) begin
      strobes = strobes + 1;
      last_strobe_cyc = cyc;
    end
  end

  // sck = clk/8, sdo set at the start of the low phase; called at a negedge.
  task automatic send_word(input logic [15:0] w, input int nbits);
    for (int i = 15; i > 15 - nbits; i--) begin
      sdo = w[i];
      repeat (4) @(negedge clk);
      sck = 1'b1;
      last_rise_cyc = cyc;
      repeat (4) @(negedge clk);
      sck = 1'b0;
    end
  endtask

  task automatic pulse_filt(input logic [9:0] v);
    filt_sample = v;
    filt_valid  = 1'b1;
    @(negedge clk);
    filt_valid  = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (busy !== 1'b0) $display("FAIL %s: busy still %b after %0d cycles, expected 0", name, busy, n);
    else n_pass++;
  endtask

  task automatic test_reset();
    reset = 1'b0; sck = 1'b0; sdo = 1'b0; filt_valid = 1'b0; filt_sample = '0;
    repeat (2) @(negedge clk);
    n_checks++; if (sample !== 10'h000) $display("FAIL rst_sample: got %h expected 000", sample); else n_pass++;
    n_checks++; if (sample_valid !== 1'b0) $display("FAIL rst_sample_valid: got %b expected 0", sample_valid); else n_pass++;
    n_checks++; if ({DACserial, DACclk, load, LDAC, busy} !== 5'b00100)
      $display("FAIL rst_dac_pins: got %b expected 00100", {DACserial, DACclk, load, LDAC, busy}); else n_pass++;
    n_checks++; if (overrun_count !== 8'd0) $display("FAIL rst_overrun: got %0d expected 0", overrun_count); else n_pass++;
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_capture(input logic [15:0] w, input logic [9:0] exp, input string name);
    int s0, lat;
    s0 = strobes;
    send_word(w, 16);
    repeat (4) @(negedge clk);
    lat = last_strobe_cyc - last_rise_cyc;
    n_checks++; if (strobes - s0 !== 1) $display("FAIL %s_strobes: got %0d expected 1", name, strobes - s0); else n_pass++;
    n_checks++; if (sample !== exp) $display("FAIL %s_sample: got %h expected %h", name, sample, exp); else n_pass++;
    n_checks++; if (lat < 1 || lat > 4) $display("FAIL %s_latency: got %0d cycles expected 1..4", name, lat); else n_pass++;
    n_checks++; if (sample_valid !== 1'b0) $display("FAIL %s_strobe_width: got %b expected 0", name, sample_valid); else n_pass++;
  endtask

  task automatic test_idle_discard();
    int s0;
    s0 = strobes;
    send_word(16'hFE00, 7);
    repeat (300) @(negedge clk);
    n_checks++; if (strobes !== s0) $display("FAIL idle_no_strobe: got %0d strobes expected 0", strobes - s0); else n_pass++;
    send_word(16'h0123, 16);
    repeat (4) @(negedge clk);
    n_checks++; if (strobes - s0 !== 1) $display("FAIL idle_strobes: got %0d expected 1", strobes - s0); else n_pass++;
    n_checks++; if (sample !== 10'h123) $display("FAIL idle_sample: got %h expected 123", sample); else n_pass++;
  endtask

  // Samples on negedges; k counts cycles after the accepting edge.
  task automatic test_dac_transfer(input logic [9:0] v, input logic [10:0] exp_bits, input string name);
    int busy_len, load_first, load_len, nfall;
    logic [10:0] got;
    logic prev_clk;
    busy_len = 0; load_first = -1; load_len = 0; nfall = 0; got = '0; prev_clk = 1'b0;
    n_checks++; if (busy !== 1'b0) $display("FAIL %s_pre_busy: got %b expected 0", name, busy); else n_pass++;
    pulse_filt(v);
    n_checks++; if ({busy, DACclk} !== 2'b11) $display("FAIL %s_first_hi: got %b expected 11", name, {busy, DACclk}); else n_pass++;
    for (int k = 0; k < 100; k++) begin
      if (busy === 1'b1) busy_len++;
      if (load === 1'b0) begin
        if (load_len == 0) load_first = k;
        load_len++;
      end
      if (prev_clk === 1'b1 && DACclk === 1'b0) begin
        got = {got[9:0], DACserial};
        nfall++;
      end
      prev_clk = DACclk;
      @(negedge clk);
    end
    n_checks++; if (busy_len !== 92) $display("FAIL %s_busy_len: got %0d expected 92", name, busy_len); else n_pass++;
    n_checks++; if (load_first !== 88) $display("FAIL %s_load_start: got %0d expected 88", name, load_first); else n_pass++;
    n_checks++; if (load_len !== 4) $display("FAIL %s_load_len: got %0d expected 4", name, load_len); else n_pass++;
    n_checks++; if (nfall !== 11) $display("FAIL %s_falls: got %0d expected 11", name, nfall); else n_pass++;
    n_checks++; if (got !== exp_bits) $display("FAIL %s_bits: got %b expected %b", name, got, exp_bits); else n_pass++;
  endtask

  task automatic test_overrun();
    int o0;
    o0 = overrun_count;
    pulse_filt(10'h100);
    repeat (9) @(negedge clk);
    pulse_filt(10'h200);
    n_checks++; if (overrun_count !== 8'(o0 + 1)) $display("FAIL ovr_second: got %0d expected %0d", overrun_count, o0 + 1); else n_pass++;
    wait_idle("ovr_wait1");

    // Strobe during the last LOAD cycle is dropped; one cycle later it is accepted.
    o0 = overrun_count;
    pulse_filt(10'h155);
    repeat (91) @(negedge clk);
    pulse_filt(10'h2AA);
    n_checks++; if (busy !== 1'b0) $display("FAIL ovr_last_load_busy: got %b expected 0", busy); else n_pass++;
    n_checks++; if (overrun_count !== 8'(o0 + 1)) $display("FAIL ovr_last_load_count: got %0d expected %0d", overrun_count, o0 + 1); else n_pass++;
    pulse_filt(10'h2AA);
    n_checks++; if (busy !== 1'b1) $display("FAIL ovr_accept_after_load: got %b expected 1", busy); else n_pass++;
    wait_idle("ovr_wait2");
  endtask

  task automatic test_saturation();
    filt_sample = 10'h3FF;
    filt_valid  = 1'b1;
    repeat (300) @(negedge clk);
    filt_valid  = 1'b0;
    n_checks++; if (overrun_count !== 8'd255) $display("FAIL sat_count: got %0d expected 255", overrun_count); else n_pass++;
    pulse_filt(10'h001);
    n_checks++; if (overrun_count !== 8'd255) $display("FAIL sat_hold: got %0d expected 255", overrun_count); else n_pass++;
    wait_idle("sat_wait");
  endtask

  task automatic test_reset_mid_transfer();
    send_word(16'hFFFF, 5);
    pulse_filt(10'h3FC);
    @(negedge clk);
    n_checks++; if (DACclk !== 1'b1) $display("FAIL mid_in_hi: got DACclk %b expected 1", DACclk); else n_pass++;
    #1 reset = 1'b0;
    #1;
    n_checks++; if ({DACserial, DACclk, load, busy} !== 4'b0010)
      $display("FAIL mid_rst_pins: got %b expected 0010", {DACserial, DACclk, load, busy}); else n_pass++;
    n_checks++; if (overrun_count !== 8'd0) $display("FAIL mid_rst_overrun: got %0d expected 0", overrun_count); else n_pass++;
    n_checks++; if (sample !== 10'h000) $display("FAIL mid_rst_sample: got %h expected 000", sample); else n_pass++;
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    test_capture(16'h0ABC, 10'h2BC, "post_rst_cap");
    test_dac_transfer(10'h2AA, 11'b000_1010_1010, "post_rst_dac");
  endtask

  initial begin
    test_reset();
    test_capture(16'h02A5, 10'h2A5, "cap_02a5");
    test_capture(16'hFD55, 10'h155, "cap_fd55");
    test_idle_discard();
    test_dac_transfer(10'h3FC, 11'b000_1111_1111, "dac_3fc");
    test_overrun();
    test_saturation();
    test_reset_mid_transfer();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1);
  end

endmodule
